// File: rtl/busca_maximo.sv
// Frame-based running maximum tracker with valid/ready streaming ports.
// Optional minimum tracking is enabled by defining MIN_TRACK_EN.

module comparador_8b (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_m,
  output logic       o_i
);
  assign o_m = (i_a > i_b);
  assign o_i = (i_a == i_b);
endmodule

module busca_maximo #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_max,
  output logic [CNT_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
`ifdef MIN_TRACK_EN
  ,
  output logic [7:0]       out_min,
  output logic [CNT_W-1:0] out_min_idx
`endif
);

  typedef enum logic [1:0] {StIdle, StAcum, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state, w_state_d;
  logic [7:0]       r_max, w_max_d;
  logic [CNT_W-1:0] r_idx, w_idx_d;
  logic [CNT_W-1:0] r_count, w_count_d;
  logic             r_sat, w_sat_d;
  logic             w_accept, w_load;
  logic             w_max_m, w_max_i;

  logic [7:0]       r_out_max;
  logic [CNT_W-1:0] r_out_idx, r_out_count;
  logic             r_out_sat;

  comparador_8b u_cmp_max (
    .i_a(in_data),
    .i_b(r_max),
    .o_m(w_max_m),
    .o_i(w_max_i)
  );

`ifdef MIN_TRACK_EN
  logic [7:0]       r_min, w_min_d;
  logic [CNT_W-1:0] r_min_idx, w_min_idx_d;
  logic [7:0]       r_out_min;
  logic [CNT_W-1:0] r_out_min_idx;
  logic             w_min_m, w_min_i;

  comparador_8b u_cmp_min (
    .i_a(in_data),
    .i_b(r_min),
    .o_m(w_min_m),
    .o_i(w_min_i)
  );

  assign out_min     = r_out_min;
  assign out_min_idx = r_out_min_idx;
`endif

  assign in_ready  = ~rst & (r_state != StDone);
  assign out_valid = (r_state == StDone);
  assign w_accept  = in_valid & in_ready;
  assign w_load    = w_accept & in_last;

  assign out_max   = r_out_max;
  assign out_idx   = r_out_idx;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

  always_comb begin
    w_state_d = r_state;
    w_max_d   = r_max;
    w_idx_d   = r_idx;
    w_count_d = r_count;
    w_sat_d   = r_sat;
`ifdef MIN_TRACK_EN
    w_min_d     = r_min;
    w_min_idx_d = r_min_idx;
`endif
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_max_d   = in_data;
          w_idx_d   = '0;
          w_count_d = CNT_W'(1);
          w_sat_d   = 1'b0;
`ifdef MIN_TRACK_EN
          w_min_d     = in_data;
          w_min_idx_d = '0;
`endif
          w_state_d = in_last ? StDone : StAcum;
        end
      end
      StAcum: begin
        if (w_accept) begin
          // Strictly greater only, so the earliest occurrence keeps the index on ties.
          if (w_max_m & ~w_max_i) begin
            w_max_d = in_data;
            w_idx_d = r_count;
          end
`ifdef MIN_TRACK_EN
          if (~w_min_m & ~w_min_i) begin
            w_min_d     = in_data;
            w_min_idx_d = r_count;
          end
`endif
          if (r_count == CntMax) begin
            w_sat_d = 1'b1;
          end else begin
            w_count_d = r_count + CNT_W'(1);
          end
          if (in_last) w_state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_max       <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_sat       <= 1'b0;
      r_out_max   <= '0;
      r_out_idx   <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_max   <= w_max_d;
      r_idx   <= w_idx_d;
      r_count <= w_count_d;
      r_sat   <= w_sat_d;
      if (w_load) begin
        r_out_max   <= w_max_d;
        r_out_idx   <= w_idx_d;
        r_out_count <= w_count_d;
        r_out_sat   <= w_sat_d;
      end
    end
  end

`ifdef MIN_TRACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_min         <= '0;
      r_min_idx     <= '0;
      r_out_min     <= '0;
      r_out_min_idx <= '0;
    end else begin
      r_min     <= w_min_d;
      r_min_idx <= w_min_idx_d;
      if (w_load) begin
        r_out_min     <= w_min_d;
        r_out_min_idx <= w_min_idx_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_busca_maximo.sv
// Self-checking bench for busca_maximo: CNT_W=8 and CNT_W=4 instances share stimulus,
// checked against frame-level expected values and a list-based reference model.

module tb_busca_maximo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic       rdy8, rdy4, ov8, ov4, sat8, sat4;
  logic [7:0] max8, max4, idx8, cnt8;
  logic [3:0] idx4, cnt4;
`ifdef MIN_TRACK_EN
  logic [7:0] min8, min4, midx8;
  logic [3:0] midx4;
`endif

  always #5 clk = ~clk;

  busca_maximo #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data),
    .in_last(in_last), .out_valid(ov8), .out_ready(out_ready), .out_max(max8),
    .out_idx(idx8), .out_count(cnt8), .out_sat(sat8)
`ifdef MIN_TRACK_EN
    , .out_min(min8), .out_min_idx(midx8)
`endif
  );

  busca_maximo #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .in_last(in_last), .out_valid(ov4), .out_ready(out_ready), .out_max(max4),
    .out_idx(idx4), .out_count(cnt4), .out_sat(sat4)
`ifdef MIN_TRACK_EN
    , .out_min(min4), .out_min_idx(midx4)
`endif
  );

  typedef struct {
    int mx; int mi; int cnt; int sat; int mn; int mni;
  } res_t;

  typedef struct {
    int         len;
    logic [7:0] s[8];
    int         hold;
    res_t       e8;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] frame_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: first-occurrence extremes over the whole frame, then clip to the counter range.
  function automatic res_t model(input logic [7:0] s[$], input int w);
    res_t r;
    int lim = (1 << w) - 1;
    r.mx = -1; r.mi = 0; r.mn = 256; r.mni = 0;
    foreach (s[i]) begin
      if (int'(s[i]) > r.mx) begin r.mx = s[i]; r.mi = i; end
      if (int'(s[i]) < r.mn) begin r.mn = s[i]; r.mni = i; end
    end
    r.cnt = (s.size() > lim) ? lim : s.size();
    r.sat = (s.size() > lim) ? 1 : 0;
    if (r.mi > lim) r.mi = lim;
    if (r.mni > lim) r.mni = lim;
    return r;
  endfunction

  task automatic cmp_all(input string tag, input res_t e8, input res_t e4);
    chk({tag, " max8"}, max8, e8.mx);
    chk({tag, " idx8"}, idx8, e8.mi);
    chk({tag, " cnt8"}, cnt8, e8.cnt);
    chk({tag, " sat8"}, sat8, e8.sat);
    chk({tag, " max4"}, max4, e4.mx);
    chk({tag, " idx4"}, idx4, e4.mi);
    chk({tag, " cnt4"}, cnt4, e4.cnt);
    chk({tag, " sat4"}, sat4, e4.sat);
`ifdef MIN_TRACK_EN
    chk({tag, " min8"}, min8, e8.mn);
    chk({tag, " midx8"}, midx8, e8.mni);
    chk({tag, " min4"}, min4, e4.mn);
    chk({tag, " midx4"}, midx4, e4.mni);
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!rdy8 && n < 20) begin n++; @(negedge clk); end
    if (!rdy8) chk("in_ready timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      send_beat(frame_q[i], (i == frame_q.size() - 1));
      if (gaps && i != frame_q.size() - 1 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Entered right after the last beat's edge: result must already be valid.
  task automatic collect(input string tag, input res_t e8, input res_t e4, input int hold);
    chk({tag, " out_valid8 latency"}, ov8, 1);
    chk({tag, " out_valid4 latency"}, ov4, 1);
    cmp_all(tag, e8, e4);
    in_valid = 1'b1; in_data = 8'hAB; in_last = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, ov8, 1);
      chk({tag, " hold in_ready"}, rdy8, 0);
      cmp_all({tag, " hold"}, e8, e4);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " release out_valid"}, ov8, 0);
    chk({tag, " release in_ready"}, rdy8, 1);
  endtask

  vec_t tbl[4];

  initial begin
    res_t e8, e4;
    int   low, nres;
    int   r_mx[2], r_mi[2], r_cnt[2];
    logic [7:0] bd[$];
    logic       bl[$];

    tbl[0].len = 3; tbl[0].s = '{3, 9, 4, 0, 0, 0, 0, 0}; tbl[0].hold = 0;
    tbl[0].e8 = '{mx: 9, mi: 1, cnt: 3, sat: 0, mn: 3, mni: 0};
    tbl[1].len = 4; tbl[1].s = '{7, 2, 7, 7, 0, 0, 0, 0}; tbl[1].hold = 1;
    tbl[1].e8 = '{mx: 7, mi: 0, cnt: 4, sat: 0, mn: 2, mni: 1};
    tbl[2].len = 1; tbl[2].s = '{8'hFF, 0, 0, 0, 0, 0, 0, 0}; tbl[2].hold = 5;
    tbl[2].e8 = '{mx: 255, mi: 0, cnt: 1, sat: 0, mn: 255, mni: 0};
    tbl[3].len = 6; tbl[3].s = '{5, 5, 1, 9, 9, 0, 0, 0}; tbl[3].hold = 2;
    tbl[3].e8 = '{mx: 9, mi: 3, cnt: 6, sat: 0, mn: 0, mni: 5};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", rdy8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset idle in_ready", rdy8, 1);
    chk("reset out_valid", ov8, 0);
    chk("reset out_max", max8, 0);
    chk("reset out_idx", idx8, 0);
    chk("reset out_count", cnt8, 0);
    chk("reset out_sat", sat8, 0);
    @(posedge clk); #1;

    foreach (tbl[v]) begin
      frame_q.delete();
      for (int i = 0; i < tbl[v].len; i++) frame_q.push_back(tbl[v].s[i]);
      send_frame(1'b0);
      e4 = model(frame_q, 4);
      collect($sformatf("vec%0d", v), tbl[v].e8, e4, tbl[v].hold);
    end

    // Saturation: 20 beats, peak 0xC8 at beat 17.
    frame_q.delete();
    for (int i = 0; i < 20; i++) frame_q.push_back((i == 17) ? 8'hC8 : 8'((i * 7) % 100 + 1));
    send_frame(1'b0);
    collect("sat", model(frame_q, 8), model(frame_q, 4), 0);
    chk("sat cnt4 const", cnt4, 15);
    chk("sat sat4 const", sat4, 1);
    chk("sat idx4 const", idx4, 15);
    chk("sat max4 const", max4, 8'hC8);
    chk("sat idx8 const", idx8, 17);

    // Mid-frame reset discards the partial frame and the previous result.
    send_beat(8'd50, 1'b0);
    send_beat(8'd60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst in_ready", rdy8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst out_valid", ov8, 0);
    chk("midrst out_max", max8, 0);
    chk("midrst out_count", cnt8, 0);
    frame_q = '{8'd10, 8'd20};
    send_frame(1'b0);
    e8 = '{mx: 20, mi: 1, cnt: 2, sat: 0, mn: 10, mni: 0};
    collect("midrst", e8, e8, 0);

    // Back-to-back frames with in_valid held high and out_ready always high.
    bd = '{8'd1, 8'd2, 8'd5, 8'd3};
    bl = '{1'b0, 1'b1, 1'b0, 1'b1};
    low = 0; nres = 0; out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (bd.size() > 0);
      if (bd.size() > 0) begin in_data = bd[0]; in_last = bl[0]; end
      @(negedge clk);
      if (!rdy8) low++;
      if (ov8 && nres < 2) begin
        r_mx[nres] = max8; r_mi[nres] = idx8; r_cnt[nres] = cnt8; nres++;
      end
      if (rdy8 && in_valid) begin void'(bd.pop_front()); void'(bl.pop_front()); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    chk("b2b in_ready low cycles", low, 2);
    chk("b2b results", nres, 2);
    if (nres == 2) begin
      chk("b2b f0 max", r_mx[0], 2);
      chk("b2b f0 idx", r_mi[0], 1);
      chk("b2b f0 cnt", r_cnt[0], 2);
      chk("b2b f1 max", r_mx[1], 5);
      chk("b2b f1 idx", r_mi[1], 0);
      chk("b2b f1 cnt", r_cnt[1], 2);
    end

    // Random frames, some narrow-valued to force ties, some past the 4-bit counter limit.
    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(1, 40);
      bit narrow = ($urandom_range(0, 1) == 1);
      frame_q.delete();
      for (int i = 0; i < len; i++)
        frame_q.push_back(narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
      send_frame(1'b1);
      collect($sformatf("rnd%0d", f), model(frame_q, 8), model(frame_q, 4),
              $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
